// File: rtl/riscv_uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, frame constants and
// elaboration-time helpers for baud-rate and FIFO sizing.
package riscv_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 11;  // start + 8 data + parity + stop

    // Clock cycles per line bit, integer truncation.
    function automatic int clks_per_bit(input longint freq, input longint baud);
        return int'(freq / baud);
    endfunction

    // True when n is a positive power of two.
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Full/empty come from the occupancy counter so the
// pointers can wrap freely modulo DEPTH. A push at full is accepted only
// when a pop happens in the same cycle, because the pop frees the slot.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: 8 data bits LSB first, even parity, one stop.
// The line flop follows the FSM state with one cycle of lag, so a byte
// pushed into an empty FIFO reaches the line two edges after the push.
// Valid/ready: a byte is taken on a rising edge where tx_valid && tx_ready;
// tx_ready is !full of the registered count, and tx_valid while full is
// dropped.
module uart_tx_fifo
    import riscv_uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 70_000_000,
    parameter int UART_BAUDRATE = 1_000_000,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rstn,
    input  logic [UART_DATA_BITS-1:0]     tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          uart_rxd_out,
    output uart_tx_state_t                dbg_state_o
);

    localparam int CPB   = clks_per_bit(CLK_FREQ_HZ, UART_BAUDRATE);
    localparam int CNT_W = (CPB < 2) ? 1 : $clog2(CPB);
    localparam int BIT_W = $clog2(UART_DATA_BITS);

    if (CPB < 2) begin : g_bad_cpb
        $fatal(1, "uart_tx_fifo: CLKS_PER_BIT must be at least 2");
    end
    if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_bad_depth
        $fatal(1, "uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    uart_tx_state_t              state_q, state_d;
    logic [CNT_W-1:0]            baud_q, baud_d;
    logic [BIT_W-1:0]            bit_q, bit_d;
    logic [UART_DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                        par_q, par_d;
    logic                        line_q, line_d;
    logic                        busy_q, busy_d;

    logic                        fifo_push;
    logic                        fifo_pop;
    logic [UART_DATA_BITS-1:0]   fifo_head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        baud_done;

    assign tx_ready     = !fifo_full;
    assign fifo_push    = tx_valid && tx_ready;
    assign baud_done    = (baud_q == CNT_W'(CPB - 1));
    assign uart_rxd_out = line_q;
    assign tx_busy      = busy_q;
    assign dbg_state_o  = state_q;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rstn),
        .push_i  (fifo_push),
        .data_i  (tx_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Next-state, baud timing, shift/parity load and line value.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + CNT_W'(1);
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        fifo_pop = 1'b0;
        line_d   = 1'b1;
        // Busy mirrors the frame on the line, lagging state like line_q.
        busy_d   = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_head;
                    par_d    = ^fifo_head;
                    state_d  = START;
                end
            end
            START: begin
                line_d = 1'b0;
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                line_d = shreg_q[0];
                if (baud_done) begin
                    baud_d  = '0;
                    shreg_d = shreg_q >> 1;
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(UART_DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                line_d = par_q;
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                line_d = 1'b1;
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next frame with no idle gap.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_head;
                        par_d    = ^fifo_head;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM, counters, shift register and registered line output.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
        end
    end

endmodule
